// File: rtl/evm_pkg.sv
// Shared constants for the XOR vote-record encoder and its key schedule.
package evm_pkg;

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned DATA_W = 80;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/evm_key_round.sv
// One key-schedule round: rotate left by ROT, then XOR the round index into the LSB byte.
module evm_key_round
  import evm_pkg::*;
#(
  parameter int unsigned ROT = 3
) (
  input  logic [0:KEY_W-1] k,
  input  logic [7:0]       idx,
  output logic [0:KEY_W-1] f
);

  logic [0:KEY_W-1] rotl;

  // Bit 0 is the MSB, so a numeric left shift moves bits toward index 0.
  assign rotl = (k << ROT) | (k >> (KEY_W - ROT));
  assign f    = rotl ^ {{(KEY_W-8){1'b0}}, idx};

endmodule

// File: rtl/evm_key_schedule.sv
// Iterated rotate/XOR key derivation, one round per clock, result held with a level key_valid.
module evm_key_schedule #(
  parameter int unsigned KEY_W  = 64,
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned ROT    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:KEY_W-1] seed_in,
  output logic             busy,
  output logic             key_valid,
  output logic [0:KEY_W-1] final_key
);
  import evm_pkg::*;

  logic [1:0]       state;
  logic [0:KEY_W-1] work;
  logic [7:0]       cnt;
  logic [0:KEY_W-1] round_out;
  logic             last_round;

  evm_key_round #(.ROT(ROT)) u_round (
    .k   (work),
    .idx (cnt),
    .f   (round_out)
  );

  assign last_round = (cnt == 8'(ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      final_key <= '0;
      work      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // final_key is left untouched so the previous key stays visible until replaced.
          if (start) begin
            work      <= seed_in;
            cnt       <= '0;
            busy      <= 1'b1;
            key_valid <= 1'b0;
            state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          work <= round_out;
          cnt  <= cnt + 8'd1;
          if (last_round) begin
            final_key <= round_out;
            key_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evm_key_schedule.sv
// Directed scoreboard bench for evm_key_schedule with ROUNDS = 1, 2 and 16 instances.
module tb_evm_key_schedule;

  logic        clk = 1'b0;
  logic        rst_v   [3];
  logic        start_v [3];
  logic [63:0] seed_v  [3];
  logic        busy_w  [3];
  logic        kv_w    [3];
  logic [63:0] fk_w    [3];

  logic [63:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  evm_key_schedule #(.KEY_W(64), .ROUNDS(1), .ROT(3)) dut_r1 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .seed_in(seed_v[0]),
    .busy(busy_w[0]), .key_valid(kv_w[0]), .final_key(fk_w[0])
  );
  evm_key_schedule #(.KEY_W(64), .ROUNDS(2), .ROT(3)) dut_r2 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .seed_in(seed_v[1]),
    .busy(busy_w[1]), .key_valid(kv_w[1]), .final_key(fk_w[1])
  );
  evm_key_schedule #(.KEY_W(64), .ROUNDS(16), .ROT(3)) dut_r16 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .seed_in(seed_v[2]),
    .busy(busy_w[2]), .key_valid(kv_w[2]), .final_key(fk_w[2])
  );

  function automatic int rnds(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  function automatic logic [63:0] ref_f(input logic [63:0] k, input logic [7:0] i);
    logic [63:0] r;
    for (int j = 0; j < 64; j++) r[j] = k[(j + 61) % 64];
    return r ^ {56'b0, i};
  endfunction

  function automatic logic [63:0] ref_key(input logic [63:0] s, input int rounds);
    logic [63:0] k = s;
    for (int i = 0; i < rounds; i++) k = ref_f(k, 8'(i));
    return k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start, then scrambles the seed; returns just after the accepting edge.
  task automatic launch(input int d, input logic [63:0] s);
    @(negedge clk);
    start_v[d] = 1'b1;
    seed_v[d]  = s;
    sb.push_back(ref_key(s, rnds(d)));
    @(negedge clk);
    start_v[d] = 1'b0;
    seed_v[d]  = ~s;
  endtask

  task automatic wait_key(input int d, input int n0, input int exp_edges, input string tag);
    int n = n0;
    logic [63:0] e;
    while (kv_w[d] !== 1'b1 && n < 300) begin
      chk({tag, "_busy_run"}, {63'b0, busy_w[d]}, 64'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_edges));
    chk({tag, "_busy_done"}, {63'b0, busy_w[d]}, 64'd0);
    if (sb.size() > 0) e = sb.pop_front();
    else e = ~fk_w[d];
    chk({tag, "_key"}, fk_w[d], e);
  endtask

  initial begin
    logic [63:0] key_1111;
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b1; start_v[d] = 1'b0; seed_v[d] = '0;
    end

    // Case 1: reset dominates a held start.
    start_v[2] = 1'b1;
    seed_v[2]  = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("c1_busy", {63'b0, busy_w[2]}, 64'd0);
      chk("c1_kv",   {63'b0, kv_w[2]},   64'd0);
      chk("c1_key",  fk_w[2],            64'd0);
    end
    for (int d = 0; d < 3; d++) rst_v[d] = 1'b0;
    start_v[2] = 1'b0;
    @(negedge clk);
    chk("c1_no_start", {63'b0, busy_w[2]}, 64'd0);

    // Case 2: ROUNDS=1.
    launch(0, 64'h1111_1111_1111_1111);
    wait_key(0, 1, 2, "c2");
    chk("c2_lit", fk_w[0], 64'h8888_8888_8888_8888);

    // Case 3: ROUNDS=2.
    launch(1, 64'h1111_1111_1111_1111);
    wait_key(1, 1, 3, "c3");
    chk("c3_lit", fk_w[1], 64'h4444_4444_4444_4445);

    // Case 4: ROUNDS=16, start re-pulsed mid-derivation.
    launch(2, 64'h0);
    repeat (3) @(negedge clk);
    start_v[2] = 1'b1;
    seed_v[2]  = 64'h1111_1111_1111_1111;
    @(negedge clk);
    start_v[2] = 1'b0;
    wait_key(2, 5, 17, "c4");

    // Case 5: back-to-back on ROUNDS=2; old key stays visible while rounds run.
    launch(1, 64'h0);
    chk("c5_kv_drop", {63'b0, kv_w[1]}, 64'd0);
    chk("c5_hold0",   fk_w[1], 64'h4444_4444_4444_4445);
    @(negedge clk);
    chk("c5_hold1",   fk_w[1], 64'h4444_4444_4444_4445);
    wait_key(1, 2, 3, "c5");
    chk("c5_lit", fk_w[1], 64'h0000_0000_0000_0001);

    // Case 6: reset after 5 rounds, then a fresh run must match an uninterrupted one.
    launch(2, 64'h1111_1111_1111_1111);
    wait_key(2, 1, 17, "c6_ref");
    key_1111 = fk_w[2];
    launch(2, 64'h1111_1111_1111_1111);
    repeat (5) @(negedge clk);
    rst_v[2] = 1'b1;
    @(negedge clk);
    rst_v[2] = 1'b0;
    chk("c6_rst_busy", {63'b0, busy_w[2]}, 64'd0);
    chk("c6_rst_kv",   {63'b0, kv_w[2]},   64'd0);
    chk("c6_rst_key",  fk_w[2],            64'd0);
    void'(sb.pop_front());
    @(negedge clk);
    chk("c6_idle", {63'b0, busy_w[2]}, 64'd0);
    launch(2, 64'h1111_1111_1111_1111);
    wait_key(2, 1, 17, "c6");
    chk("c6_same", fk_w[2], key_1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
